// File: rtl/axil_write_reg_bank.sv
// AXI4-Lite write-side register bank: captures the write address, byte-merges
// committed data into a word array, and reports per-register pulses and BRESP.
module axil_write_reg_bank #(
    parameter int                      C_ADDR_WIDTH  = 8,
    parameter int                      C_DATA_WIDTH  = 32,
    parameter int                      C_NUM_REGS    = 16,
    parameter logic [C_DATA_WIDTH-1:0] C_RESET_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [C_ADDR_WIDTH-1:0]            awaddr,
    input  logic                               awreg_en,
    input  logic [C_DATA_WIDTH-1:0]            wdata,
    input  logic [C_DATA_WIDTH/8-1:0]          wstrb,
    input  logic                               wreg_en,
    input  logic                               bvalid,
    input  logic                               bready,
    output logic [1:0]                         bresp,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
    output logic [C_NUM_REGS-1:0]              wr_pulse,
    output logic [7:0]                         err_count
);

    localparam int IDX_W  = $clog2(C_NUM_REGS);
    localparam int STRB_W = C_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
    logic [C_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [7:0]              err_count_q, err_count_d;
    logic                    pending_q, pending_d;

    logic [C_ADDR_WIDTH-1:0] wordAddr;
    logic [IDX_W-1:0]        index;
    logic                    inRange;

    // Power-of-two bank: in range exactly when no word-address bit above the index is set.
    always_comb begin
        wordAddr = addr_q >> 2;
        index    = addr_q[IDX_W+1:2];
        inRange  = (wordAddr[C_ADDR_WIDTH-1:IDX_W] == '0);
    end

    always_comb begin
        addr_d = awreg_en ? awaddr : addr_q;
    end

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (wreg_en && inRange) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    regs_d[index][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
            wr_pulse_d[index] = 1'b1;
        end
    end

    // Response code and error count only move on a commit; the handshake leaves bresp alone.
    always_comb begin
        bresp_d     = bresp_q;
        err_count_d = err_count_q;
        pending_d   = pending_q;
        if (wreg_en) begin
            pending_d = 1'b1;
            if (inRange) begin
                bresp_d = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
        end else if (bvalid && bready && pending_q) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wr_pulse_q  <= '0;
            bresp_q     <= RESP_OKAY;
            err_count_q <= '0;
            pending_q   <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= C_RESET_VALUE;
            end
        end else begin
            addr_q      <= addr_d;
            wr_pulse_q  <= wr_pulse_d;
            bresp_q     <= bresp_d;
            err_count_q <= err_count_d;
            pending_q   <= pending_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_flatten
        assign reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[i];
    end

    assign bresp     = bresp_q;
    assign wr_pulse  = wr_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_axil_write_reg_bank.sv
// Self-checking bench for axil_write_reg_bank: table of writes plus corner-case
// sequences, with a reference model feeding a per-cycle scoreboard.
module tb_axil_write_reg_bank;

    localparam int NR = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   awaddr;
    logic         awreg_en;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wreg_en;
    logic         bvalid;
    logic         bready;
    logic [1:0]   bresp;
    logic [511:0] reg_out;
    logic [15:0]  wr_pulse;
    logic [7:0]   err_count;

    axil_write_reg_bank dut (
        .clk       (clk),
        .reset     (reset),
        .awaddr    (awaddr),
        .awreg_en  (awreg_en),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wreg_en   (wreg_en),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .reg_out   (reg_out),
        .wr_pulse  (wr_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [15:0]  pulse;
        logic [1:0]   bresp;
        logic [7:0]   err;
        logic [511:0] regs;
    } exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [15:0] expPulse;
        logic [1:0]  expBresp;
        logic [7:0]  expErr;
        int          expIdx;
        logic [31:0] expWord;
    } vec_t;

    exp_t sbQueue[$];
    vec_t vecs[8];

    int numChecks = 0;
    int numFails  = 0;

    logic [31:0] model [NR];
    logic [7:0]  modelAddr;
    logic [1:0]  modelBresp;
    logic [7:0]  modelErr;

    function automatic logic [511:0] modelFlat();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*32 +: 32] = model[i];
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        modelAddr  = 8'h00;
        modelBresp = 2'b00;
        modelErr   = 8'h00;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQueue.size() == 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sbQueue.pop_front();
            check({e.name, " wr_pulse"}, 512'(wr_pulse), 512'(e.pulse));
            check({e.name, " bresp"}, 512'(bresp), 512'(e.bresp));
            check({e.name, " err_count"}, 512'(err_count), 512'(e.err));
            check({e.name, " reg_out"}, reg_out, e.regs);
        end
    endtask

    // Drives one cycle at a negedge, predicts the post-edge state, then checks it at the next negedge.
    task automatic applyStimulus(input string name, input logic aw, input logic [7:0] addr,
                                 input logic we, input logic [31:0] data, input logic [3:0] strb);
        exp_t        e;
        int          word;
        logic [15:0] pulse;
        pulse    = '0;
        awreg_en = aw;
        awaddr   = addr;
        wreg_en  = we;
        wdata    = data;
        wstrb    = strb;
        if (we) begin
            word = int'(modelAddr >> 2);
            if (word < NR) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[word][b*8 +: 8] = data[b*8 +: 8];
                pulse[word] = 1'b1;
                modelBresp  = 2'b00;
            end else begin
                modelBresp = 2'b10;
                if (modelErr != 8'hFF) modelErr = modelErr + 8'd1;
            end
        end
        if (aw) modelAddr = addr;
        e.name  = name;
        e.pulse = pulse;
        e.bresp = modelBresp;
        e.err   = modelErr;
        e.regs  = modelFlat();
        sbQueue.push_back(e);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleCycle();
        applyStimulus("idle", 1'b0, 8'h00, 1'b0, 32'h0, 4'h0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        awaddr = 8'h00; awreg_en = 1'b0; wdata = 32'h0; wstrb = 4'h0;
        wreg_en = 1'b0; bvalid = 1'b0; bready = 1'b0;

        vecs[0] = '{8'h08, 32'hDEADBEEF, 4'hF, 16'h0004, 2'b00, 8'd0, 2,  32'hDEADBEEF};
        vecs[1] = '{8'h0B, 32'h11223344, 4'h5, 16'h0004, 2'b00, 8'd0, 2,  32'hDE22BE44};
        vecs[2] = '{8'h40, 32'hFFFFFFFF, 4'hF, 16'h0000, 2'b10, 8'd1, -1, 32'h0};
        vecs[3] = '{8'h3C, 32'h12345678, 4'h0, 16'h8000, 2'b00, 8'd1, 15, 32'h0};
        vecs[4] = '{8'h3C, 32'hA5A5A5A5, 4'h8, 16'h8000, 2'b00, 8'd1, 15, 32'hA5000000};
        vecs[5] = '{8'h00, 32'hCAFEF00D, 4'h3, 16'h0001, 2'b00, 8'd1, 0,  32'h0000F00D};
        vecs[6] = '{8'hFC, 32'h00000001, 4'hF, 16'h0000, 2'b10, 8'd2, -1, 32'h0};
        vecs[7] = '{8'h04, 32'h11111111, 4'h6, 16'h0002, 2'b00, 8'd2, 1,  32'h00111100};

        // Reset asserted between clock edges must clear outputs without a clock.
        #3 reset = 1'b1;
        #1;
        check("reset reg_out", reg_out, 512'h0);
        check("reset bresp", 512'(bresp), 512'h0);
        check("reset wr_pulse", 512'(wr_pulse), 512'h0);
        check("reset err_count", 512'(err_count), 512'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d capture", i), 1'b1, vecs[i].addr, 1'b0, 32'h0, 4'h0);
            applyStimulus($sformatf("vec%0d commit", i), 1'b0, 8'h00, 1'b1, vecs[i].data, vecs[i].strb);
            check($sformatf("vec%0d table wr_pulse", i), 512'(wr_pulse), 512'(vecs[i].expPulse));
            check($sformatf("vec%0d table bresp", i), 512'(bresp), 512'(vecs[i].expBresp));
            check($sformatf("vec%0d table err_count", i), 512'(err_count), 512'(vecs[i].expErr));
            if (vecs[i].expIdx >= 0)
                check($sformatf("vec%0d table word", i),
                      512'(reg_out[vecs[i].expIdx*32 +: 32]), 512'(vecs[i].expWord));
            idleCycle();
        end

        // Address tracks awaddr while awreg_en is high; the last sampled value is used.
        applyStimulus("track 00", 1'b1, 8'h00, 1'b0, 32'h0, 4'h0);
        applyStimulus("track 04", 1'b1, 8'h04, 1'b0, 32'h0, 4'h0);
        applyStimulus("track 0C", 1'b1, 8'h0C, 1'b0, 32'h0, 4'h0);
        applyStimulus("track commit", 1'b0, 8'h20, 1'b1, 32'h5A5A5A5A, 4'hF);
        check("track reg3", 512'(reg_out[3*32 +: 32]), 512'h5A5A5A5A);
        check("track pulse", 512'(wr_pulse), 512'h0008);
        idleCycle();

        // Same-edge capture+commit uses the old address, then a back-to-back commit uses the new one.
        applyStimulus("b2b capture", 1'b1, 8'h10, 1'b0, 32'h0, 4'h0);
        applyStimulus("b2b first", 1'b1, 8'h14, 1'b1, 32'h01020304, 4'hF);
        check("b2b first pulse", 512'(wr_pulse), 512'h0010);
        applyStimulus("b2b second", 1'b0, 8'h00, 1'b1, 32'h0A0B0C0D, 4'hF);
        check("b2b second pulse", 512'(wr_pulse), 512'h0020);
        idleCycle();

        // Response handshake must not disturb a held SLVERR.
        applyStimulus("resp capture", 1'b1, 8'h80, 1'b0, 32'h0, 4'h0);
        applyStimulus("resp commit", 1'b0, 8'h00, 1'b1, 32'h12345678, 4'hF);
        bvalid = 1'b1; bready = 1'b1;
        idleCycle();
        bvalid = 1'b0; bready = 1'b0;
        idleCycle();
        check("resp bresp held", 512'(bresp), 512'h2);

        // Error counter saturation.
        applyStimulus("sat capture", 1'b1, 8'h40, 1'b0, 32'h0, 4'h0);
        for (int n = 0; n < 256; n++)
            applyStimulus("sat write", 1'b0, 8'h00, 1'b1, 32'hFFFFFFFF, 4'hF);
        check("sat err_count", 512'(err_count), 512'hFF);
        idleCycle();

        // Async reset after address capture discards the pending address.
        applyStimulus("mid capture", 1'b1, 8'h08, 1'b0, 32'h0, 4'h0);
        awreg_en = 1'b0; wreg_en = 1'b0; awaddr = 8'h00;
        #2 reset = 1'b1;
        #1;
        check("mid reset reg_out", reg_out, 512'h0);
        check("mid reset bresp", 512'(bresp), 512'h0);
        check("mid reset err_count", 512'(err_count), 512'h0);
        check("mid reset wr_pulse", 512'(wr_pulse), 512'h0);
        #1 reset = 1'b0;
        modelReset();
        @(negedge clk);
        check("post reset wr_pulse", 512'(wr_pulse), 512'h0);
        applyStimulus("post reset commit", 1'b0, 8'h08, 1'b1, 32'hDEADBEEF, 4'hF);
        check("post reset reg0", 512'(reg_out[31:0]), 512'hDEADBEEF);
        check("post reset reg2", 512'(reg_out[2*32 +: 32]), 512'h0);
        check("post reset bresp", 512'(bresp), 512'h0);
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
